// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler.
package div_sched_pkg;

  localparam int unsigned QW  = 14;
  localparam int unsigned OPW = 32;
  localparam logic [QW-1:0] QSAT = 14'h3FFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    SETTLE,
    DONE
  } state_t;

  // Divide-by-zero or a quotient that cannot fit in QW bits.
  function automatic logic pre_err(input logic [OPW-1:0] dvd, input logic [OPW-1:0] dvs);
    return (dvs == '0) || ((dvd >> QW) >= dvs);
  endfunction

endpackage

// File: rtl/div_sched_if.sv
// Request/response handshake bundle between requesters and the scheduler.
interface div_sched_if
  import div_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [OPW*NREQ-1:0] req_dividend;
  logic [OPW*NREQ-1:0] req_divisor;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [QW-1:0]       rsp_quot;
  logic                rsp_err;

  modport master (
    output req_valid, req_dividend, req_divisor,
    input  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_err
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor,
    output req_ready, rsp_valid, rsp_id, rsp_quot, rsp_err
  );

endinterface

// File: rtl/div_sched_rr_arb.sv
// Round-robin grant: first valid requester at or after the pointer wins.
module rr_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gid,
  output logic            any
);
  localparam int unsigned SW = IDW + 1;

  logic [IDW-1:0] ptr;
  logic [SW-1:0]  cand;

  always_comb begin
    grant = '0;
    gid   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + SW'(i);
      if (cand >= SW'(NREQ)) cand = cand - SW'(NREQ);
      if (!any && req[cand[IDW-1:0]]) begin
        any                   = 1'b1;
        grant[cand[IDW-1:0]]  = 1'b1;
        gid                   = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
    end
  end

endmodule

// File: rtl/div_sched.sv
// Shares one external repeated-subtraction divider between NREQ requesters,
// screening zero/overflow operands and sequencing the divider's load/enable protocol.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned LOAD_CYC   = 2,
  parameter int unsigned SETTLE_CYC = 3,
  parameter int unsigned TIMEOUT    = 16400
) (
  input  logic           clk,
  input  logic           rstn,
  div_sched_if.slave     bus,
  output logic           busy,
  output logic [OPW-1:0] div_dividend,
  output logic [OPW-1:0] div_divisor,
  output logic           div_enable,
  input  logic           div_state,
  input  logic [QW-1:0]  div_result
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            cnt_clr, acc, fin_err, fin_ok;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gid, op_id;
  logic            any;
  logic [OPW-1:0]  sel_dvd, sel_dvs;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (bus.req_valid),
    .advance (acc),
    .grant   (grant),
    .gid     (gid),
    .any     (any)
  );

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gid == IDW'(i)) begin
        sel_dvd = bus.req_dividend[i*OPW +: OPW];
        sel_dvs = bus.req_divisor[i*OPW +: OPW];
      end
    end
  end

  always_comb begin
    state_n       = state;
    cnt_clr       = 1'b0;
    acc           = 1'b0;
    fin_err       = 1'b0;
    fin_ok        = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    div_enable    = 1'b0;
    busy          = (state != IDLE);
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (any) begin
          acc           = 1'b1;
          bus.req_ready = grant;
          if (pre_err(sel_dvd, sel_dvs)) begin
            state_n = DONE;
            fin_err = 1'b1;
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        if (cnt == CW'(LOAD_CYC - 1)) begin
          state_n = RUN;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        div_enable = 1'b1;
        // Completion wins over timeout so a done on the last allowed cycle is kept.
        if (div_state) begin
          state_n = SETTLE;
          cnt_clr = 1'b1;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = DONE;
          fin_err = 1'b1;
        end
      end
      SETTLE: begin
        div_enable = 1'b1;
        if (cnt == CW'(SETTLE_CYC - 1)) begin
          state_n = DONE;
          fin_ok  = 1'b1;
        end
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        state_n       = IDLE;
        cnt_clr       = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      op_id        <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      bus.rsp_id   <= '0;
      bus.rsp_quot <= '0;
      bus.rsp_err  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_clr ? '0 : cnt + 1'b1;
      if (acc) begin
        div_dividend <= sel_dvd;
        div_divisor  <= sel_dvs;
        op_id        <= gid;
      end
      // A pre-check error finishes in the accept cycle, before op_id is loaded.
      if (fin_err) begin
        bus.rsp_id   <= acc ? gid : op_id;
        bus.rsp_quot <= QSAT;
        bus.rsp_err  <= 1'b1;
      end else if (fin_ok) begin
        bus.rsp_id   <= op_id;
        bus.rsp_quot <= div_result;
        bus.rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched with a behavioural stand-in for the divider.
module tb_div_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        busy;
  logic [31:0] div_dividend, div_divisor;
  logic        div_enable;
  logic        div_state;
  logic [13:0] div_result;

  div_sched_if #(.NREQ(2)) bus ();

  div_sched #(
    .NREQ       (2),
    .LOAD_CYC   (2),
    .SETTLE_CYC (3),
    .TIMEOUT    (64)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .busy         (busy),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_enable   (div_enable),
    .div_state    (div_state),
    .div_result   (div_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider stand-in: done after run_delay enabled cycles; exact multiples stall forever.
  int run_delay = 0;
  int dcnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_state  <= 1'b0;
      div_result <= '0;
      dcnt       <= 0;
    end else if (!div_enable) begin
      div_state <= 1'b0;
      dcnt      <= 0;
    end else begin
      dcnt <= dcnt + 1;
      if (!div_state && div_divisor != 0 && (div_dividend % div_divisor) != 0 && dcnt == run_delay) begin
        div_state  <= 1'b1;
        div_result <= 14'(div_dividend / div_divisor);
      end
    end
  end

  typedef struct {
    int          id;
    logic [13:0] quot;
    logic        err;
    int          lat;
    int          en;
    int          ld;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per response pulse.
  initial begin
    int   en_cnt = 0;
    int   ld_cnt = 0;
    bit   prev_rsp = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        en_cnt   = 0;
        ld_cnt   = 0;
        prev_rsp = 0;
      end else begin
        if (prev_rsp) chk("busy_after_done", busy, 0);
        if (bus.rsp_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", bus.rsp_id, e.id);
            chk("rsp_quot", bus.rsp_quot, e.quot);
            chk("rsp_err", bus.rsp_err, e.err);
            chk("latency", cyc - e.acc, e.lat);
            chk("enable_cycles", en_cnt, e.en);
            chk("load_cycles", ld_cnt, e.ld);
            chk("busy_in_done", busy, 1);
          end
          en_cnt = 0;
          ld_cnt = 0;
        end else begin
          if (div_enable) en_cnt++;
          if (busy && !div_enable) ld_cnt++;
        end
        prev_rsp = bus.rsp_valid;
      end
    end
  end

  task automatic set_ops(input int id, input logic [31:0] dvd, input logic [31:0] dvs);
    if (id == 0) begin
      bus.req_dividend[31:0] = dvd;
      bus.req_divisor[31:0]  = dvs;
    end else begin
      bus.req_dividend[63:32] = dvd;
      bus.req_divisor[63:32]  = dvs;
    end
  endtask

  task automatic push(input int id, input logic [13:0] q, input logic err,
                      input int lat, input int en, input int ld);
    exp_t e;
    e.id = id; e.quot = q; e.err = err; e.lat = lat; e.en = en; e.ld = ld; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic issue(input int id, input logic [31:0] dvd, input logic [31:0] dvs, input int d,
                       input bit do_push, input logic [13:0] q, input logic err,
                       input int lat, input int en, input int ld);
    bit got = 0;
    @(negedge clk);
    set_ops(id, dvd, dvs);
    run_delay = d;
    bus.req_valid[id] = 1'b1;
    #1;
    for (int n = 0; n < 200 && !got; n++) begin
      if (bus.req_ready[id]) got = 1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (!got) begin
      chk("grant_timeout", 0, 1);
    end else begin
      chk("ready_onehot", bus.req_ready, 1 << id);
      if (do_push) push(id, q, err, lat, en, ld);
      @(posedge clk);
      #1;
    end
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic pair(input logic [31:0] d0, input logic [31:0] s0, input logic [13:0] q0,
                      input logic [31:0] d1, input logic [31:0] s1, input logic [13:0] q1);
    logic [1:0] rdy;
    @(negedge clk);
    set_ops(0, d0, s0);
    set_ops(1, d1, s1);
    run_delay = 0;
    bus.req_valid = 2'b11;
    for (int g = 0; g < 2; g++) begin
      bit got = 0;
      #1;
      for (int n = 0; n < 200 && !got; n++) begin
        if (bus.req_ready != 0) got = 1;
        else begin
          @(negedge clk);
          #1;
        end
      end
      if (!got) begin
        chk("rr_grant_timeout", 0, 1);
      end else begin
        rdy = bus.req_ready;
        chk("rr_grant", rdy, 1 << g);
        push(g, (g == 0) ? q0 : q1, 1'b0, 8, 5, 2);
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~rdy;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && !busy) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_enable", div_enable, 0);
    chk("reset_dividend", div_dividend, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 100/7 -> 14; RUN k = 3+2 = 5
    issue(0, 100, 7, 3, 1, 14'd14, 1'b0, 11, 8, 2);
    wait_idle();
    // 6/7 -> 0; done seen immediately, k = 2
    issue(1, 6, 7, 0, 1, 14'd0, 1'b0, 8, 5, 2);
    wait_idle();
    // divide by zero
    issue(0, 55, 0, 0, 1, 14'h3FFF, 1'b1, 1, 0, 0);
    wait_idle();
    // quotient overflow
    issue(0, 32'h0010_0000, 1, 0, 1, 14'h3FFF, 1'b1, 1, 0, 0);
    wait_idle();
    // exact multiple stalls the divider; timeout after 64 RUN cycles
    issue(0, 21, 7, 0, 1, 14'h3FFF, 1'b1, 67, 64, 2);
    wait_idle();

    // restart from pointer 0 for the arbitration rounds
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    pair(100, 7, 14'd14, 6, 7, 14'd0);
    wait_idle();
    pair(45, 4, 14'd11, 1000, 3, 14'd333);
    wait_idle();

    // reset while the divider is running: no response, everything cleared
    issue(0, 100, 7, 40, 0, 14'd0, 1'b0, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("run_enable", div_enable, 1);
    rstn = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_quot", bus.rsp_quot, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_dividend", div_dividend, 0);
    chk("rst_div_divisor", div_divisor, 0);
    chk("rst_div_enable", div_enable, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
